// File: rtl/spi_pkg.sv
// Shared definitions for the clk-domain SPI responder.
// Mode constants, FSM state encoding and counter sizing.
package spi_pkg;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/spi_slave_sync_if.sv
// Word-level tx/rx handshake bundle of the SPI responder.
// The responder uses the slave modport, its user the master modport.
interface spi_slave_sync_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             rx_overrun;
    logic             tx_underrun;

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid,
        output rx_overrun, tx_underrun
    );

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid,
        input  rx_overrun, tx_underrun
    );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with registered rise/fall strobes.
// Level and strobes come out aligned to the same clk cycle.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_dly;
    logic              r_rise;
    logic              r_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_dly  <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_dly  <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_dly;
            r_fall <= ~r_sync[STAGES-1] & r_dly;
        end
    end

    assign o_level = r_dly;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
endmodule

// File: rtl/spi_slave_sync.sv
// SPI mode-0 responder running entirely in the clk domain.
// Oversamples sclk/cs_n/mosi; words move over valid/ready.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] TX_DEFAULT  = '0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
    output logic busy,
    spi_slave_sync_if.slave bus
);
    localparam int             CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_rise, w_fall, w_mosi, w_settled;
    logic [WIDTH-1:0] w_rx_word, w_load_word;

    state_e             r_state;
    logic               r_armed;
    logic [SYNC_STAGES:0] r_settle;
    logic [SYNC_STAGES:0] r_mosi_sync;
    logic [CW-1:0]      r_bit_cnt;
    logic [WIDTH-2:0]   r_rx_shift;
    logic [WIDTH-1:0]   r_rx_data;
    logic               r_rx_valid;
    logic               r_rx_ovr;
    logic               r_tx_und;
    logic [WIDTH-1:0]   r_tx_hold;
    logic               r_full;
    logic [WIDTH-2:0]   r_tx_shift;
    logic               r_pend;
    logic               r_pend_hold;
    logic               r_miso;
    logic               r_oe;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .i_d(sclk),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .i_d(cs_n),
        .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    // Extra mosi stage lines data up with the registered sclk strobes
    assign w_mosi      = r_mosi_sync[SYNC_STAGES];
    assign w_rise      = w_sclk_rise & w_sclk_lvl;
    assign w_fall      = w_sclk_fall & ~w_sclk_lvl;
    assign w_settled   = r_settle[SYNC_STAGES];
    assign w_rx_word   = {r_rx_shift, w_mosi};
    assign w_load_word = r_full ? r_tx_hold : TX_DEFAULT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_armed     <= 1'b0;
            r_settle    <= '0;
            r_mosi_sync <= '0;
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_ovr    <= 1'b0;
            r_tx_und    <= 1'b0;
            r_tx_hold   <= '0;
            r_full      <= 1'b0;
            r_tx_shift  <= '0;
            r_pend      <= 1'b0;
            r_pend_hold <= 1'b0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
        end else begin
            r_rx_ovr    <= 1'b0;
            r_tx_und    <= 1'b0;
            r_settle    <= {r_settle[SYNC_STAGES-1:0], 1'b1};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-1:0], mosi};
            // Only a cs_n seen high after reset makes the next fall genuine
            if (w_settled && w_cs_lvl)
                r_armed <= 1'b1;
            if (r_rx_valid && bus.rx_ready)
                r_rx_valid <= 1'b0;
            if (bus.tx_valid && !r_full) begin
                r_tx_hold <= bus.tx_data;
                r_full    <= 1'b1;
            end
            unique case (1'b1)
                (r_state == IDLE): begin
                    r_bit_cnt <= '0;
                    r_oe      <= 1'b0;
                    if (w_cs_fall && r_armed) begin
                        r_state    <= SHIFT;
                        r_oe       <= 1'b1;
                        r_miso     <= w_load_word[WIDTH-1];
                        r_tx_shift <= w_load_word[WIDTH-2:0];
                        if (r_full) r_full   <= 1'b0;
                        else        r_tx_und <= 1'b1;
                    end
                end
                (r_state == SHIFT): begin
                    if (w_cs_rise) begin
                        r_state   <= IDLE;
                        r_oe      <= 1'b0;
                        r_miso    <= 1'b0;
                        r_bit_cnt <= '0;
                        r_pend    <= 1'b0;
                    end else if (w_rise) begin
                        r_rx_shift <= w_rx_word[WIDTH-2:0];
                        // Boundary reload is committed only once the word starts
                        if (r_pend) begin
                            r_pend <= 1'b0;
                            if (r_pend_hold) r_full   <= 1'b0;
                            else             r_tx_und <= 1'b1;
                        end
                        if (r_bit_cnt == LAST) begin
                            r_bit_cnt  <= '0;
                            r_rx_data  <= w_rx_word;
                            r_rx_valid <= 1'b1;
                            r_rx_ovr   <= r_rx_valid && !bus.rx_ready;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_fall) begin
                        if (r_bit_cnt != '0) begin
                            r_miso     <= r_tx_shift[WIDTH-2];
                            r_tx_shift <= r_tx_shift << 1;
                        end else begin
                            r_miso      <= w_load_word[WIDTH-1];
                            r_tx_shift  <= w_load_word[WIDTH-2:0];
                            r_pend      <= 1'b1;
                            r_pend_hold <= r_full;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign miso            = r_miso;
    assign miso_oe         = r_oe;
    assign busy            = ~w_cs_lvl;
    assign bus.tx_ready    = ~r_full;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.rx_overrun  = r_rx_ovr;
    assign bus.tx_underrun = r_tx_und;
endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: table of single-word frames plus
// hand-written multi-word, overrun, abort and reset sequences.
module tb_spi_slave_sync;
    localparam int HALF = 8;
    localparam int SS   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic miso, miso_oe, busy;

    spi_slave_sync_if #(.WIDTH(8)) u_bus ();

    spi_slave_sync #(
        .WIDTH(8), .TX_DEFAULT(8'hFF), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n),
        .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
        .busy(busy), .bus(u_bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_und   = 0;
    int n_ovr   = 0;
    logic [7:0] q_rx[$];
    logic [7:0] r0, r1;

    typedef struct {
        bit         load;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_mi;
        int         exp_und;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (u_bus.tx_underrun) n_und++;
            if (u_bus.rx_overrun)  n_ovr++;
            if (u_bus.rx_valid && u_bus.rx_ready) begin
                if (q_rx.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got %0h expected none",
                             u_bus.rx_data);
                end else begin
                    check("rx_word", u_bus.rx_data, q_rx.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_xfer(input logic b, input bit lat, output logic s);
        mosi = b;
        tick(HALF);
        s = miso;
        sclk = 1'b1;
        if (lat) begin
            tick(SS + 1);
            check("lat_early", u_bus.rx_valid, 1'b0);
            tick(1);
            check("lat_on", u_bus.rx_valid, 1'b1);
            tick(HALF - SS - 2);
        end else begin
            tick(HALF);
        end
        sclk = 1'b0;
    endtask

    task automatic word_xfer(input logic [7:0] mo, input bit lat,
                             output logic [7:0] mi);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(mo[i], lat && (i == 0), s);
            mi[i] = s;
        end
    endtask

    task automatic frame(input int n, input logic [7:0] m0, m1,
                         input bit lat, output logic [7:0] o0, o1);
        cs_n = 1'b0;
        tick(HALF);
        word_xfer(m0, lat, o0);
        o1 = '0;
        if (n > 1) word_xfer(m1, 1'b0, o1);
        check("busy_on", busy, 1'b1);
        check("oe_on", miso_oe, 1'b1);
        tick(HALF);
        cs_n = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic load_tx(input logic [7:0] w);
        bit ok;
        ok = 1'b0;
        u_bus.tx_data  = w;
        u_bus.tx_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (u_bus.tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        u_bus.tx_valid = 1'b0;
        check("tx_accept", ok, 1'b1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_miso"}, miso, 1'b0);
        check({tag, "_oe"}, miso_oe, 1'b0);
        check({tag, "_txrdy"}, u_bus.tx_ready, 1'b1);
        check({tag, "_rxdata"}, u_bus.rx_data, 8'h00);
        check({tag, "_rxvalid"}, u_bus.rx_valid, 1'b0);
        check({tag, "_ovr"}, u_bus.rx_overrun, 1'b0);
        check({tag, "_und"}, u_bus.tx_underrun, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic s;
        logic [7:0] mo;
        u_bus.tx_data  = '0;
        u_bus.tx_valid = 1'b0;
        u_bus.rx_ready = 1'b1;

        tbl[0] = '{1'b1, 8'h3C, 8'hA5, 8'h3C, 0};
        tbl[1] = '{1'b0, 8'h00, 8'h12, 8'hFF, 1};
        tbl[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 0};
        tbl[3] = '{1'b1, 8'h80, 8'h01, 8'h80, 0};
        tbl[4] = '{1'b1, 8'h7E, 8'h81, 8'h7E, 0};

        tick(3);
        check_reset_outs("rst");
        rst_n = 1'b1;
        tick(6);

        foreach (tbl[i]) begin
            n_und = 0;
            n_ovr = 0;
            if (tbl[i].load) load_tx(tbl[i].tx);
            q_rx.push_back(tbl[i].mo);
            frame(1, tbl[i].mo, 8'h00, i == 0, r0, r1);
            tick(4);
            check("miso_word", r0, tbl[i].exp_mi);
            check("underrun_cnt", n_und, tbl[i].exp_und);
            check("overrun_cnt", n_ovr, 0);
            check("tx_ready_idle", u_bus.tx_ready, 1'b1);
            check("oe_off", miso_oe, 1'b0);
            check("miso_off", miso, 1'b0);
        end

        // two words under one cs_n, second tx word loaded mid-frame
        n_und = 0;
        load_tx(8'hC3);
        q_rx.push_back(8'h5A);
        q_rx.push_back(8'h7E);
        fork
            frame(2, 8'h5A, 8'h7E, 1'b0, r0, r1);
            begin
                tick(30);
                load_tx(8'h81);
            end
        join
        tick(4);
        check("two_w0", r0, 8'hC3);
        check("two_w1", r1, 8'h81);
        check("two_und", n_und, 0);
        check("two_txrdy", u_bus.tx_ready, 1'b1);

        // overrun with consumer stalled
        n_ovr = 0;
        u_bus.rx_ready = 1'b0;
        frame(2, 8'h11, 8'h22, 1'b0, r0, r1);
        check("ovr_cnt", n_ovr, 1);
        check("ovr_data", u_bus.rx_data, 8'h22);
        check("ovr_valid", u_bus.rx_valid, 1'b1);
        q_rx.push_back(8'h22);
        u_bus.rx_ready = 1'b1;
        tick(3);
        check("ovr_drain", q_rx.size(), 0);

        // abort after 5 bits; cs_n rises together with the sclk fall
        cs_n = 1'b0;
        tick(HALF);
        for (int b = 0; b < 5; b++) bit_xfer(1'b1, 1'b0, s);
        cs_n = 1'b1;
        tick(SS + 2);
        check("abort_oe", miso_oe, 1'b0);
        check("abort_miso", miso, 1'b0);
        tick(10);
        check("abort_rxv", u_bus.rx_valid, 1'b0);
        load_tx(8'h96);
        q_rx.push_back(8'hA5);
        frame(1, 8'hA5, 8'h00, 1'b0, r0, r1);
        check("after_abort", r0, 8'h96);

        // reset in the middle of bit 3
        mo = 8'hC3;
        cs_n = 1'b0;
        tick(HALF);
        for (int b = 7; b > 4; b--) bit_xfer(mo[b], 1'b0, s);
        tick(2);
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        tick(3);
        rst_n = 1'b1;
        n_und = 0;
        for (int b = 4; b >= 0; b--) bit_xfer(mo[b], 1'b0, s);
        tick(HALF);
        check("midrst_oe", miso_oe, 1'b0);
        check("midrst_und", n_und, 0);
        cs_n = 1'b1;
        tick(20);
        check("midrst_rxv", u_bus.rx_valid, 1'b0);
        load_tx(8'hE7);
        q_rx.push_back(8'h3C);
        frame(1, 8'h3C, 8'h00, 1'b0, r0, r1);
        tick(4);
        check("after_rst", r0, 8'hE7);
        check("final_queue", q_rx.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
